// File: rtl/sram_like_resp.sv
// SRAM-like request/response memory endpoint. It performs each access when the
// request is accepted and returns the responses in request order after a fixed latency.
module sram_like_resp #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        accept_hold,
  input  logic        resp_hold,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [3:0] LOAD_CNT = 4'(LATENCY - 1);

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       q_rdata [DEPTH];
  logic [3:0]        q_cnt [DEPTH];
  logic [DEPTH-1:0]  q_valid;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] word_idx;
  logic              push;
  logic              pop;
  logic              unused_ok;

  // Byte offset and upper address bits alias; size is informational only.
  assign word_idx  = addr[ADDR_W+1:2];
  assign unused_ok = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  // Handshake: a request transfers on a cycle where req and addr_ok are both high.
  // data_ok is a one-cycle strobe that the master must take; it pops the head.
  assign addr_ok = !reset && !accept_hold && (count < FULL_CNT);
  assign push    = req && addr_ok;
  assign data_ok = !reset && q_valid[head] && (q_cnt[head] == 4'd0) && !resp_hold;
  assign pop     = data_ok;
  assign rdata   = data_ok ? q_rdata[head] : 32'd0;

  // The store is never reset, so accepted writes survive a reset.
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Countdowns keep running under resp_hold, so a held response is ready on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_cnt[i]   <= 4'd0;
        q_rdata[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (tail == PW'(i))) begin
          q_valid[i] <= 1'b1;
          q_cnt[i]   <= LOAD_CNT;
          q_rdata[i] <= wr ? 32'd0 : mem[word_idx];
        end else begin
          if (q_cnt[i] != 4'd0) q_cnt[i] <= q_cnt[i] - 4'd1;
          if (pop && (head == PW'(i))) q_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_resp.sv
// Directed bench for sram_like_resp: a per-cycle vector table on a LATENCY=2 instance
// plus hand sequences for reset, mid-flight reset and a full stall on a LATENCY=8 instance.
module tb_sram_like_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr, accept_hold, resp_hold;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;

  logic        s_req, s_wr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] exp_q[$];
  int first_acc, first_dok, first_stall, reopen, got;

  always #5 clk = ~clk;

  sram_like_resp #(.ADDR_W(10), .DEPTH(4), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .accept_hold(accept_hold), .resp_hold(resp_hold),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sram_like_resp #(.ADDR_W(10), .DEPTH(4), .LATENCY(8)) u_slow (
    .clk(clk), .reset(reset), .req(s_req), .wr(s_wr), .size(2'd2), .wstrb(s_wstrb),
    .addr(s_addr), .wdata(s_wdata), .accept_hold(1'b0), .resp_hold(1'b0),
    .addr_ok(s_addr_ok), .data_ok(s_data_ok), .rdata(s_rdata)
  );

  typedef struct {
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ahold;
    logic        rhold;
    logic        e_aok;
    logic        e_dok;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(input logic rq, input logic w, input logic [3:0] st,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic ah, input logic rh, input logic ea,
                              input logic ed, input logic [31:0] er);
    vec_t v;
    v.req = rq; v.wr = w; v.wstrb = st; v.addr = a; v.wdata = d;
    v.ahold = ah; v.rhold = rh; v.e_aok = ea; v.e_dok = ed; v.e_rdata = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rq, input logic w, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    req = rq; wr = w; wstrb = st; addr = a; wdata = d;
  endtask

  // Issues 5 back-to-back requests to the slow instance, honouring addr_ok.
  task automatic slow_burst(input logic is_wr);
    int issued;
    int cyc;
    logic [31:0] e;
    issued = 0; cyc = 0; got = 0;
    first_acc = -1; first_dok = -1; first_stall = -1; reopen = -1;
    while ((issued < 5 || got < 5) && cyc < 60) begin
      s_req   = (issued < 5);
      s_wr    = is_wr;
      s_wstrb = 4'hF;
      s_addr  = 32'(issued * 4);
      s_wdata = 32'hA000_0000 + 32'(issued);
      @(negedge clk);
      if (s_data_ok) begin
        if (exp_q.size() == 0) begin
          check("slow unexpected data_ok", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("slow resp %0d rdata", got), s_rdata, e);
        end
        if (first_dok < 0) first_dok = cyc;
        got++;
      end
      if (s_req) begin
        if (s_addr_ok) begin
          exp_q.push_back(is_wr ? 32'd0 : (32'hA000_0000 + 32'(issued)));
          if (first_acc < 0) first_acc = cyc;
          if (first_stall >= 0 && reopen < 0) reopen = cyc;
          issued++;
        end else if (first_stall < 0) begin
          first_stall = cyc;
        end
      end
      step();
      cyc++;
    end
    s_req = 1'b0;
    check("slow burst response count", 32'(got), 32'd5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(1, 1, 4'hF, 32'h10,   32'hDEADBEEF, 0, 0, 1, 0, 32'h0);
    vecs[1]  = mk(1, 0, 4'h0, 32'h10,   32'h0,        0, 0, 1, 0, 32'h0);
    vecs[2]  = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 1, 32'h0);
    vecs[3]  = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 1, 32'hDEADBEEF);
    vecs[4]  = mk(1, 1, 4'hF, 32'h0,    32'h11223344, 0, 0, 1, 0, 32'h0);
    vecs[5]  = mk(1, 1, 4'h2, 32'h0,    32'hAABBCCDD, 0, 0, 1, 0, 32'h0);
    vecs[6]  = mk(1, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 1, 32'h0);
    vecs[7]  = mk(1, 0, 4'h0, 32'h1003, 32'h0,        0, 0, 1, 1, 32'h0);
    vecs[8]  = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 1, 32'h1122CC44);
    vecs[9]  = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 1, 32'h1122CC44);
    vecs[10] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 0, 32'h0);
    vecs[11] = mk(1, 1, 4'hF, 32'h10,   32'h12345678, 1, 0, 0, 0, 32'h0);
    vecs[12] = mk(1, 1, 4'hF, 32'h10,   32'h12345678, 1, 0, 0, 0, 32'h0);
    vecs[13] = mk(1, 0, 4'h0, 32'h10,   32'h0,        0, 0, 1, 0, 32'h0);
    vecs[14] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 0, 32'h0);
    vecs[15] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 1, 32'hDEADBEEF);
    vecs[16] = mk(1, 1, 4'hF, 32'h20,   32'hCAFEF00D, 0, 0, 1, 0, 32'h0);
    vecs[17] = mk(1, 0, 4'h0, 32'h10,   32'h0,        0, 1, 1, 0, 32'h0);
    vecs[18] = mk(1, 0, 4'h0, 32'h0,    32'h0,        0, 1, 1, 0, 32'h0);
    vecs[19] = mk(1, 0, 4'h0, 32'h20,   32'h0,        0, 1, 1, 0, 32'h0);
    vecs[20] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 0, 0, 32'h0);
    vecs[21] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 0, 0, 32'h0);
    vecs[22] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 0, 0, 32'h0);
    vecs[23] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 0, 1, 32'h0);
    vecs[24] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 1, 32'hDEADBEEF);
    vecs[25] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 1, 32'h1122CC44);
    vecs[26] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 1, 32'hCAFEF00D);
    vecs[27] = mk(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 1, 0, 32'h0);

    // Reset with a request held high: outputs low, request must not be taken.
    reset = 1'b1; size = 2'd2; accept_hold = 1'b0; resp_hold = 1'b0;
    s_req = 1'b0; s_wr = 1'b0; s_wstrb = 4'h0; s_addr = 32'h0; s_wdata = 32'h0;
    drive(1, 1, 4'hF, 32'h30, 32'h55);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check($sformatf("reset cyc%0d addr_ok", i), 32'(addr_ok), 32'd0);
      check($sformatf("reset cyc%0d data_ok", i), 32'(data_ok), 32'd0);
      check($sformatf("reset cyc%0d rdata", i), rdata, 32'd0);
      check($sformatf("reset cyc%0d slow addr_ok", i), 32'(s_addr_ok), 32'd0);
    end
    step();
    reset = 1'b0;
    drive(0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("post-reset addr_ok", 32'(addr_ok), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check($sformatf("post-reset idle%0d data_ok", i), 32'(data_ok), 32'd0);
    end

    for (int i = 0; i < 28; i++) begin
      step();
      drive(vecs[i].req, vecs[i].wr, vecs[i].wstrb, vecs[i].addr, vecs[i].wdata);
      accept_hold = vecs[i].ahold;
      resp_hold   = vecs[i].rhold;
      @(negedge clk);
      check($sformatf("v%0d addr_ok", i), 32'(addr_ok), 32'(vecs[i].e_aok));
      check($sformatf("v%0d data_ok", i), 32'(data_ok), 32'(vecs[i].e_dok));
      check($sformatf("v%0d rdata", i), rdata, vecs[i].e_rdata);
    end
    accept_hold = 1'b0;
    resp_hold   = 1'b0;

    // Mid-flight reset: two pending reads vanish, an earlier write persists.
    step(); drive(1, 1, 4'hF, 32'h40, 32'h0BADF00D);
    step(); drive(0, 0, 4'h0, 32'h0, 32'h0);
    step();
    @(negedge clk);
    check("mf write resp data_ok", 32'(data_ok), 32'd1);
    check("mf write resp rdata", rdata, 32'd0);
    step(); drive(1, 0, 4'h0, 32'h10, 32'h0);
    step(); drive(1, 0, 4'h0, 32'h0, 32'h0);
    step(); drive(0, 0, 4'h0, 32'h0, 32'h0); reset = 1'b1;
    @(negedge clk);
    check("mf reset0 data_ok", 32'(data_ok), 32'd0);
    check("mf reset0 addr_ok", 32'(addr_ok), 32'd0);
    step();
    @(negedge clk);
    check("mf reset1 data_ok", 32'(data_ok), 32'd0);
    step(); reset = 1'b0;
    @(negedge clk);
    check("mf after reset addr_ok", 32'(addr_ok), 32'd1);
    check("mf after reset data_ok", 32'(data_ok), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      check($sformatf("mf drained%0d data_ok", i), 32'(data_ok), 32'd0);
    end
    step(); drive(1, 0, 4'h0, 32'h40, 32'h0);
    step(); drive(0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("mf persist early data_ok", 32'(data_ok), 32'd0);
    step();
    @(negedge clk);
    check("mf persist data_ok", 32'(data_ok), 32'd1);
    check("mf persist rdata", rdata, 32'h0BADF00D);

    // Full stall on the LATENCY=8 instance: fill the words, then read them back.
    step();
    slow_burst(1'b1);
    slow_burst(1'b0);
    check("slow stall cycle", 32'(first_stall), 32'd4);
    check("slow first accept cycle", 32'(first_acc), 32'd0);
    check("slow first data_ok latency", 32'(first_dok - first_acc), 32'd8);
    check("slow reopen after first pop", 32'(reopen), 32'(first_dok + 1));
    check("slow scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
